// File: rtl/stream_upsize_var.sv
// rtl/stream_upsize_var.sv - packs narrow beats into a wide word with runtime ratio
// Partial words are flushed on s_last_i or after TIMEOUT_CYCLES idle cycles.
module stream_upsize_var #(
   parameter int T_DATA_WIDTH     = 8,
   parameter int T_DATA_RATIO_MAX = 4,
   parameter int TIMEOUT_CYCLES   = 16
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic [$clog2(T_DATA_RATIO_MAX+1)-1:0]      ratio_i,
   input  logic [T_DATA_WIDTH-1:0]                    s_data_i,
   input  logic                                       s_last_i,
   input  logic                                       s_valid_i,
   output logic                                       s_ready_o,
   output logic [T_DATA_WIDTH-1:0]                    m_data_o [T_DATA_RATIO_MAX],
   output logic [T_DATA_RATIO_MAX-1:0]                m_keep_o,
   output logic                                       m_last_o,
   output logic                                       m_valid_o,
   input  logic                                       m_ready_i,
   output logic                                       flush_o
);

   localparam int RW = $clog2(T_DATA_RATIO_MAX + 1);
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [RW-1:0] RMAX = RW'(T_DATA_RATIO_MAX);
   localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES);

   logic [T_DATA_WIDTH-1:0]     lanes_q  [T_DATA_RATIO_MAX];
   logic [T_DATA_WIDTH-1:0]     lanes_d  [T_DATA_RATIO_MAX];
   logic [T_DATA_WIDTH-1:0]     m_data_q [T_DATA_RATIO_MAX];
   logic [T_DATA_WIDTH-1:0]     m_data_d [T_DATA_RATIO_MAX];
   logic [T_DATA_RATIO_MAX-1:0] m_keep_q, m_keep_d;
   logic                        m_last_q, m_last_d;
   logic                        m_valid_q, m_valid_d;
   logic [RW-1:0]               idx_q, idx_d;
   logic [RW-1:0]               ratio_q, ratio_d;
   logic [CW-1:0]               cnt_q, cnt_d;

   logic [RW-1:0] ratio_in, ratio_eff;
   logic          accept, complete, flush, load, filled;

   always_comb begin
      ratio_in = ratio_i;
      if (ratio_i == '0) begin
         ratio_in = RW'(1);
      end else if (ratio_i > RMAX) begin
         ratio_in = RMAX;
      end
      ratio_eff = (idx_q == '0) ? ratio_in : ratio_q;

      s_ready_o = !rst_i && (!m_valid_q || m_ready_i);
      accept    = s_valid_i && s_ready_o;
      complete  = accept && (s_last_i || (idx_q == ratio_eff - RW'(1)));
      // An accepted beat always wins over a timeout firing in the same cycle.
      flush     = (TIMEOUT_CYCLES != 0) && !rst_i && !accept && (idx_q != '0) &&
                  (cnt_q == CMAX) && (!m_valid_q || m_ready_i);
      load      = complete || flush;
      flush_o   = flush;

      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_last_d  = m_last_q;
      m_valid_d = m_valid_q;
      idx_d     = idx_q;
      ratio_d   = ratio_q;
      cnt_d     = cnt_q;
      filled    = 1'b0;

      for (int k = 0; k < T_DATA_RATIO_MAX; k++) begin
         lanes_d[k] = lanes_q[k];
         if (accept && (idx_q == RW'(k))) begin
            lanes_d[k] = s_data_i;
         end
      end

      if (load) begin
         for (int k = 0; k < T_DATA_RATIO_MAX; k++) begin
            filled      = (RW'(k) < idx_q) || (complete && (RW'(k) == idx_q));
            m_data_d[k] = filled ? lanes_d[k] : '0;
            m_keep_d[k] = filled;
         end
         m_last_d  = complete && s_last_i;
         m_valid_d = 1'b1;
      end else if (m_ready_i) begin
         m_valid_d = 1'b0;
      end

      if (accept && (idx_q == '0)) begin
         ratio_d = ratio_in;
      end

      if (load) begin
         idx_d = '0;
      end else if (accept) begin
         idx_d = idx_q + RW'(1);
      end

      if (accept || flush || (idx_q == '0)) begin
         cnt_d = '0;
      end else if (cnt_q != CMAX) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lanes_q   <= '{default: '0};
         m_data_q  <= '{default: '0};
         m_keep_q  <= '0;
         m_last_q  <= 1'b0;
         m_valid_q <= 1'b0;
         idx_q     <= '0;
         ratio_q   <= RW'(1);
         cnt_q     <= '0;
      end else begin
         lanes_q   <= lanes_d;
         m_data_q  <= m_data_d;
         m_keep_q  <= m_keep_d;
         m_last_q  <= m_last_d;
         m_valid_q <= m_valid_d;
         idx_q     <= idx_d;
         ratio_q   <= ratio_d;
         cnt_q     <= cnt_d;
      end
   end

   assign m_data_o  = m_data_q;
   assign m_keep_o  = m_keep_q;
   assign m_last_o  = m_last_q;
   assign m_valid_o = m_valid_q;

endmodule

// File: tb/tb_stream_upsize_var.sv
// tb/tb_stream_upsize_var.sv - directed bench for stream_upsize_var
module tb_stream_upsize_var;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] ratio;
   logic [7:0] s_data;
   logic       s_last;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] m_data [4];
   logic [3:0] m_keep;
   logic       m_last;
   logic       m_valid;
   logic       m_ready;
   logic       flush;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   stream_upsize_var #(
      .T_DATA_WIDTH(8),
      .T_DATA_RATIO_MAX(4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .ratio_i(ratio),
      .s_data_i(s_data),
      .s_last_i(s_last),
      .s_valid_i(s_valid),
      .s_ready_o(s_ready),
      .m_data_o(m_data),
      .m_keep_o(m_keep),
      .m_last_o(m_last),
      .m_valid_o(m_valid),
      .m_ready_i(m_ready),
      .flush_o(flush)
   );

   function automatic logic [31:0] word();
      return {m_data[3], m_data[2], m_data[1], m_data[0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                           input logic l);
      chk({tag, "_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_data"}, word(), d);
      chk({tag, "_keep"}, 32'(m_keep), 32'(k));
      chk({tag, "_last"}, 32'(m_last), 32'(l));
   endtask

   task automatic beat(input logic [7:0] d, input logic l);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      s_last  = 1'b0;
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      ratio   = 3'd4;
      s_data  = 8'h00;
      s_last  = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_keep", 32'(m_keep), 32'd0);
      chk("rst_data", word(), 32'd0);
      chk("rst_last", 32'(m_last), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // full word of four, last on final beat
      beat(8'h11, 1'b0);
      beat(8'h22, 1'b0);
      beat(8'h33, 1'b0);
      chk("full_lat", 32'(m_valid), 32'd0);
      beat(8'h44, 1'b1);
      chk_word("full", 32'h44332211, 4'b1111, 1'b1);
      idle(1);
      chk("full_drain", 32'(m_valid), 32'd0);

      // short packet
      beat(8'hA1, 1'b0);
      beat(8'hA2, 1'b0);
      beat(8'hA3, 1'b1);
      chk_word("short", 32'h00A3A2A1, 4'b0111, 1'b1);
      idle(1);

      // ratio clamp high, then ratio 0 meaning 1 back-to-back
      ratio = 3'd7;
      beat(8'h01, 1'b0);
      beat(8'h02, 1'b0);
      beat(8'h03, 1'b0);
      beat(8'h04, 1'b0);
      chk_word("clamp7", 32'h04030201, 4'b1111, 1'b0);
      ratio = 3'd0;
      beat(8'h05, 1'b0);
      chk_word("r0_a", 32'h00000005, 4'b0001, 1'b0);
      beat(8'h06, 1'b0);
      chk_word("r0_b", 32'h00000006, 4'b0001, 1'b0);
      idle(1);

      // ratio change mid-word ignored
      ratio = 3'd2;
      beat(8'h71, 1'b0);
      ratio = 3'd4;
      beat(8'h72, 1'b0);
      chk_word("midratio", 32'h00007271, 4'b0011, 1'b0);
      idle(1);

      // timeout flush
      beat(8'h01, 1'b0);
      beat(8'h02, 1'b0);
      idle(15);
      chk("to_early", 32'(flush), 32'd0);
      idle(1);
      chk("to_pulse", 32'(flush), 32'd1);
      chk("to_pulse_nv", 32'(m_valid), 32'd0);
      idle(1);
      chk("to_pulse_end", 32'(flush), 32'd0);
      chk_word("to_word", 32'h00000201, 4'b0011, 1'b0);
      idle(1);

      // beat arriving as timeout would fire wins
      beat(8'h01, 1'b0);
      beat(8'h02, 1'b0);
      idle(16);
      chk("prio_armed", 32'(flush), 32'd1);
      s_valid = 1'b1;
      s_data  = 8'h03;
      #1;
      chk("prio_noflush", 32'(flush), 32'd0);
      @(negedge clk);
      chk("prio_nov", 32'(m_valid), 32'd0);
      beat(8'h04, 1'b0);
      chk_word("prio_word", 32'h04030201, 4'b1111, 1'b0);
      idle(1);

      // backpressure
      ratio   = 3'd1;
      m_ready = 1'b0;
      beat(8'h55, 1'b0);
      chk_word("bp_load", 32'h00000055, 4'b0001, 1'b0);
      s_data = 8'h66;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_sready", 32'(s_ready), 32'd0);
         chk_word("bp_hold", 32'h00000055, 4'b0001, 1'b0);
      end
      m_ready = 1'b1;
      #1;
      chk("bp_release", 32'(s_ready), 32'd1);
      @(negedge clk);
      chk_word("bp_next", 32'h00000066, 4'b0001, 1'b0);
      idle(1);
      chk("bp_drain", 32'(m_valid), 32'd0);

      // reset mid-word discards the partial
      ratio = 3'd4;
      beat(8'h01, 1'b0);
      beat(8'h02, 1'b0);
      s_valid = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      chk("mrst_sready", 32'(s_ready), 32'd0);
      chk("mrst_valid", 32'(m_valid), 32'd0);
      chk("mrst_data", word(), 32'd0);
      chk("mrst_keep", 32'(m_keep), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      beat(8'h11, 1'b0);
      beat(8'h12, 1'b0);
      beat(8'h13, 1'b0);
      chk("mrst_nov", 32'(m_valid), 32'd0);
      beat(8'h14, 1'b0);
      chk_word("mrst_word", 32'h14131211, 4'b1111, 1'b0);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
